// File: rtl/fp_div_if.sv
// Start/Done handshake and result bus between the FP-unit controller and fp_div.
interface fp_div_if;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Done;
  logic [31:0] P;
  logic        OF;
  logic        UF;
  logic        NanF;
  logic        InfF;
  logic        DNF;
  logic        ZF;

  modport master (output Start, A, B,
                  input  Done, P, OF, UF, NanF, InfF, DNF, ZF);
  modport slave  (input  Start, A, B,
                  output Done, P, OF, UF, NanF, InfF, DNF, ZF);
endinterface

// File: rtl/fp_div.sv
// Sequential binary32 divider: restoring radix-2 mantissa divide, one quotient bit per clock,
// truncating result, denormal inputs flushed to zero.
module fp_div (
  input  logic     clk,
  input  logic     rst,
  fp_div_if.slave  bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic [4:0]  cnt;
  logic [31:0] a_p0, b_p0;
  logic [24:0] r_p1, q_p1;
  logic [23:0] mb_p1;
  logic        done_r;
  logic [31:0] p_r;
  logic [5:0]  flags_r;     // {OF, UF, NanF, InfF, DNF, ZF}

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sign, za, zb, ia, ib, na, nb, dnf;
  logic        is_nan, is_inf, is_zero, special;
  logic [37:0] spec_res;
  logic [24:0] diff;
  logic        ge;

  // Exponent rebias, normalisation shift and saturation to Inf / zero.
  function automatic logic [37:0] norm_pack(input logic s, input logic [7:0] xa,
                                            input logic [7:0] xb, input logic [24:0] q);
    logic signed [9:0] e;
    logic [22:0]       frac;
    e = $signed({2'b00, xa}) - $signed({2'b00, xb}) + 10'sd127;
    if (q[24]) begin
      frac = q[23:1];
    end else begin
      frac = q[22:0];
      e    = e - 10'sd1;
    end
    if (e >= 10'sd255)
      norm_pack = {s, 8'hFF, 23'd0, 6'b100100};
    else if (e <= 10'sd0)
      norm_pack = {s, 31'd0, 6'b010001};
    else
      norm_pack = {s, e[7:0], frac, 6'b000000};
  endfunction

  assign ea   = a_p0[30:23];
  assign eb   = b_p0[30:23];
  assign fa   = a_p0[22:0];
  assign fb   = b_p0[22:0];
  assign sign = a_p0[31] ^ b_p0[31];
  // Zero test covers denormals too, which is what flushes them.
  assign za   = (ea == 8'h00);
  assign zb   = (eb == 8'h00);
  assign ia   = (ea == 8'hFF) && (fa == 23'd0);
  assign ib   = (eb == 8'hFF) && (fb == 23'd0);
  assign na   = (ea == 8'hFF) && (fa != 23'd0);
  assign nb   = (eb == 8'hFF) && (fb != 23'd0);
  assign dnf  = (za && (fa != 23'd0)) || (zb && (fb != 23'd0));

  // Evaluated in priority order: NaN, then Inf, then zero.
  assign is_nan  = na || nb || (za && zb) || (ia && ib);
  assign is_inf  = ia || zb;
  assign is_zero = za || ib;
  assign special = is_nan || is_inf || is_zero;

  always_comb begin
    spec_res = {sign, 31'd0, 4'b0000, dnf, 1'b1};
    if (is_nan)
      spec_res = {32'h7FC00000, 3'b001, 1'b0, dnf, 1'b0};
    else if (is_inf)
      spec_res = {sign, 8'hFF, 23'd0, 3'b000, 1'b1, dnf, 1'b0};
  end

  assign ge   = (r_p1 >= {1'b0, mb_p1});
  assign diff = r_p1 - {1'b0, mb_p1};

  // Stage p0: operand latch; stage p1: restoring divider datapath.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.Start) begin
          a_p0 <= bus.A;
          b_p0 <= bus.B;
        end
      end
      CHECK: begin
        r_p1  <= {2'b01, fa};
        mb_p1 <= {1'b1, fb};
        q_p1  <= '0;
      end
      DIV: begin
        if (ge) begin
          q_p1 <= {q_p1[23:0], 1'b1};
          r_p1 <= {diff[23:0], 1'b0};
        end else begin
          q_p1 <= {q_p1[23:0], 1'b0};
          r_p1 <= {r_p1[23:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Stage p2: control FSM and registered result / flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      done_r  <= 1'b0;
      p_r     <= '0;
      flags_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE:  if (bus.Start) state <= CHECK;
        CHECK: begin
          if (special) begin
            state          <= DONE;
            done_r         <= 1'b1;
            {p_r, flags_r} <= spec_res;
          end else begin
            state <= DIV;
            cnt   <= '0;
          end
        end
        DIV: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) state <= NORM;
        end
        NORM: begin
          state          <= DONE;
          done_r         <= 1'b1;
          {p_r, flags_r} <= norm_pack(sign, ea, eb, q_p1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Done = done_r;
  assign bus.P    = p_r;
  assign bus.OF   = flags_r[5];
  assign bus.UF   = flags_r[4];
  assign bus.NanF = flags_r[3];
  assign bus.InfF = flags_r[2];
  assign bus.DNF  = flags_r[1];
  assign bus.ZF   = flags_r[0];
endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div: directed corner cases, reset abort, Start glitches and random operands
// checked against an integer-arithmetic reference model.
module tb_fp_div;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  fp_div_if bus ();
  fp_div dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {bus.OF, bus.UF, bus.NanF, bus.InfF, bus.DNF, bus.ZF};
  endfunction

  // Returns {special, P, OF, UF, NanF, InfF, DNF, ZF}.
  function automatic logic [38:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s, za, zb, ia, ib, na, nb, dnf;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb, frac;
    longint ma, mb, q;
    int e;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 8'hFF) && (fa == 0); ib = (eb == 8'hFF) && (fb == 0);
    na = (ea == 8'hFF) && (fa != 0); nb = (eb == 8'hFF) && (fb != 0);
    dnf = (za && fa != 0) || (zb && fb != 0);
    if (na || nb || (za && zb) || (ia && ib))
      return {1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b0, dnf, 1'b0};
    if (ia || zb)
      return {1'b1, s, 8'hFF, 23'd0, 1'b0, 1'b0, 1'b0, 1'b1, dnf, 1'b0};
    if (za || ib)
      return {1'b1, s, 31'd0, 1'b0, 1'b0, 1'b0, 1'b0, dnf, 1'b1};
    ma = longint'({1'b1, fa});
    mb = longint'({1'b1, fb});
    q  = (ma << 24) / mb;
    e  = int'(ea) - int'(eb) + 127;
    if (q >= (longint'(1) << 24)) frac = 23'(q >> 1);
    else begin
      frac = 23'(q);
      e    = e - 1;
    end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'd0, 6'b100100};
    if (e <= 0)   return {1'b0, s, 31'd0, 6'b010001};
    return {1'b0, s, 8'(e), frac, 6'b000000};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int          k;
    logic        s;
    logic [22:0] f;
    k = $urandom_range(0, 15);
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case (k)
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, f | 23'd1};
      3:       return {s, 8'h00, f | 23'd1};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  // One operation; glitch>0 pulses Start with other operands n cycles after acceptance.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int glitch);
    logic [38:0] m;
    int n;
    m = model(a, b);
    @(negedge clk);
    bus.Start = 1'b1; bus.A = a; bus.B = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    n = 0;
    while (!bus.Done && n < 60) begin
      if (glitch > 0 && n == glitch) begin
        bus.Start = 1'b1; bus.A = 32'h3F800000; bus.B = 32'h40000000;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.Start = 1'b0;
    end
    check({tag, "_latency"}, 64'(n), m[38] ? 64'd1 : 64'd27);
    check({tag, "_P"}, 64'(bus.P), 64'(m[37:6]));
    check({tag, "_flags"}, 64'(flags_now()), 64'(m[5:0]));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.Done), 64'd0);
  endtask

  logic [31:0] da [12];
  logic [31:0] db [12];
  int seen;

  initial begin
    da = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h3F800000, 32'h00000000, 32'h7F800000,
           32'h7F000000, 32'h00800000, 32'h00000001, 32'h3F800000, 32'h7FC00001, 32'h40000000};
    db = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000, 32'h7F800000,
           32'h3E800000, 32'h7F000000, 32'h3F800000, 32'h00000001, 32'h3F800000, 32'hFF800000};
    rst = 1'b1;
    bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_done", 64'(bus.Done), 64'd0);
    check("reset_P", 64'(bus.P), 64'd0);
    check("reset_flags", 64'(flags_now()), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op($sformatf("dir%0d", i), da[i], db[i], 0);

    // Reset asserted at edge 10 of a normal operation.
    @(negedge clk);
    bus.Start = 1'b1; bus.A = 32'h40C00000; bus.B = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_done", 64'(bus.Done), 64'd0);
    check("abort_P", 64'(bus.P), 64'd0);
    check("abort_flags", 64'(flags_now()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) seen = 1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    run_op("after_reset", 32'h40C00000, 32'h40000000, 0);

    run_op("glitch5", 32'h3F800000, 32'h40400000, 5);
    run_op("glitch20", 32'hC0C00000, 32'h40000000, 20);

    for (int i = 0; i < 60; i++) run_op($sformatf("rnd%0d", i), rnd_fp(), rnd_fp(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
